// File: rtl/sccb_pkg.sv
// sccb_pkg: shared state encoding, SCCB data width and default timing for the SCCB write arbiter
package sccb_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_XFER,
    ST_GAP
  } state_t;
  localparam int SCCB_DW = 8;
  localparam int DEF_GAP_CYC = 50;
  localparam int DEF_START_WAIT = 64;
  localparam int DEF_TIMEOUT_CYC = 2500000;
endpackage

// File: rtl/sccb_arbiter_if.sv
// sccb_arbiter_if: requester handshake plus SCCB_send launch/busy signals of the arbiter
interface sccb_arbiter_if
  import sccb_pkg::*;
#(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0] req, gnt, done, err;
  logic [SCCB_DW*N_REQ-1:0] req_addr, req_value;
  logic sccb_send, sccb_busy, bus_idle;
  logic [SCCB_DW-1:0] sccb_address, sccb_value;
  modport slave (
    input  req, req_addr, req_value, sccb_busy,
    output gnt, done, err, sccb_send, sccb_address, sccb_value, bus_idle
  );
  modport master (
    output req, req_addr, req_value, sccb_busy,
    input  gnt, done, err, sccb_send, sccb_address, sccb_value, bus_idle
  );
endinterface

// File: rtl/sccb_rr_pick.sv
// sccb_rr_pick: combinational round-robin picker, first set request at or after ptr (wrapping)
module sccb_rr_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         onehot,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  // rotate so bit 0 is the requester the pointer names, then take the lowest set offset
  assign rot = N_REQ'({req, req} >> ptr);
  always_comb begin
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (rot[k]) off = IW'(k);
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = sum >= (IW+1)'(N_REQ) ? IW'(sum - (IW+1)'(N_REQ)) : IW'(sum);
  assign any = |req;
  assign onehot = any ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/sccb_arbiter.sv
// sccb_arbiter: round-robin sharing of one SCCB_send write engine between N_REQ requesters.
// Define SCCB_ARB_TIMEOUT_EN to add the start/busy watchdog that ends a stuck write with an err pulse.
module sccb_arbiter
  import sccb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int GAP_CYC = DEF_GAP_CYC
`ifdef SCCB_ARB_TIMEOUT_EN
  ,
  parameter int START_WAIT  = DEF_START_WAIT,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input logic           clk,
  input logic           rst_n,
  sccb_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int GW = $clog2(GAP_CYC + 1);
  state_t state, nxt;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0] pick_idx, ptr, g;
  logic any, busy_q, busy_qq, rise, fall, gap_end, wd_exp;
  logic [GW-1:0] gap_cnt;

  sccb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(bus.req), .ptr(ptr), .onehot(pick_oh), .idx(pick_idx), .any(any)
  );

  assign rise = busy_q & ~busy_qq;
  assign fall = ~busy_q & busy_qq;
  assign gap_end = gap_cnt == GW'(GAP_CYC - 1);
  assign bus.bus_idle = state == ST_IDLE;

`ifdef SCCB_ARB_TIMEOUT_EN
  localparam int WD_MAX = START_WAIT > TIMEOUT_CYC ? START_WAIT : TIMEOUT_CYC;
  localparam int WW = $clog2(WD_MAX + 1);
  logic [WW-1:0] wd_cnt;
  // a busy edge in the expiry cycle wins over the watchdog
  assign wd_exp = (state == ST_WAIT_BUSY && !rise && wd_cnt == WW'(START_WAIT - 1)) ||
                  (state == ST_XFER && !fall && wd_cnt == WW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd_cnt <= '0;
    else wd_cnt <= state == nxt ? wd_cnt + 1'b1 : '0;
`else
  assign wd_exp = 1'b0;
  assign bus.err = '0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:      nxt = any ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH:    nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: nxt = rise ? ST_XFER : wd_exp ? ST_GAP : ST_WAIT_BUSY;
      ST_XFER:      nxt = (fall || wd_exp) ? ST_GAP : ST_XFER;
      ST_GAP:       nxt = gap_end ? ST_IDLE : ST_GAP;
      default:      nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy_q <= 1'b0;
      busy_qq <= 1'b0;
      bus.gnt <= '0;
      bus.done <= '0;
`ifdef SCCB_ARB_TIMEOUT_EN
      bus.err <= '0;
`endif
      bus.sccb_send <= 1'b0;
      bus.sccb_address <= '0;
      bus.sccb_value <= '0;
      ptr <= '0;
      g <= '0;
      gap_cnt <= '0;
    end else begin
      busy_q <= bus.sccb_busy;
      busy_qq <= busy_q;
      bus.done <= '0;
      gap_cnt <= state == ST_GAP ? gap_cnt + 1'b1 : '0;
      if (state == ST_IDLE && any) begin
        bus.gnt <= pick_oh;
        g <= pick_idx;
        bus.sccb_address <= SCCB_DW'(bus.req_addr >> {pick_idx, 3'b000});
        bus.sccb_value <= SCCB_DW'(bus.req_value >> {pick_idx, 3'b000});
      end
      if (state == ST_LAUNCH) begin
        bus.sccb_send <= ~bus.sccb_send;
        ptr <= g == IW'(N_REQ - 1) ? '0 : g + 1'b1;
      end
      if (state == ST_XFER && fall) begin
        bus.done <= bus.gnt;
        bus.gnt <= '0;
      end
`ifdef SCCB_ARB_TIMEOUT_EN
      bus.err <= '0;
      if (wd_exp) begin
        bus.err <= bus.gnt;
        bus.gnt <= '0;
      end
`endif
    end
endmodule
